programm_lader: RTL and testbench
=================================

# programm_lader

Boot-time sequencer that copies a program image from the SD card reader into the CPU's single-port RAM, then releases the CPU from reset. It sits between `SDKarte` and `RAM` in the top level and owns the RAM write port until loading completes. Afterwards, the top level hands the RAM port back to the CPU.

## Interface
- `ADRESSBREITE`, 16: RAM word-address width; capacity is 4·2^ADRESSBREITE bytes.
- `PAUSE`, 16: idle cycles enforced after each SD response before the next request. The SD controller corrupts data on back-to-back requests.
- `STARTADRESSE`, 0: SD byte address of the image header.

Ports:
- `Clock`  in  1  single clock; all logic on posedge.
- `Reset`  in  1  synchronous, active-high.
- `SDLesen`  out  1  one-cycle read request.
- `SDAdresse`  out  32  SD byte address; stable from `SDLesen` until `SDFertig`.
- `SDDaten`  in  8  returned byte; valid only while `SDFertig`=1.
- `SDFertig`  in  1  one-cycle response strobe.
- `SDBusy`  in  1  SD controller busy; no request while high.
- `RAMSchreibenAn`  out  1  one-cycle RAM write strobe.
- `RAMAdresse`  out  ADRESSBREITE  RAM word address.
- `RAMDatenRein`  out  32  RAM write data.
- `CPUReset`  out  1  holds the CPU in reset until the load succeeds.
- `Fertig`  out  1  level; image loaded, CPU running.
- `Fehler`  out  1  level; invalid header, load aborted.
- `Zustand`  out  3  current state, for LED debug.

## Operation
- Image format:
  - 4-byte little-endian byte count N at `STARTADRESSE`.
  - N payload bytes follow at `STARTADRESSE`+4 onward.
  - Payload byte k goes to RAM word k/4, bits [8·(k mod 4)+7 : 8·(k mod 4)], little-endian.
- States and transitions:
  - RESET (0): clear all registers → GROESSELADEN.
  - GROESSELADEN (1): issue requests for header bytes 0..3 → AUFGROESSEWARTEN after each request.
  - AUFGROESSEWARTEN (2): on `SDFertig`, shift the byte into N. If fewer than 4 header bytes received → GROESSELADEN; after the 4th → PRUEFEN.
  - PRUEFEN (3): if N==0 or N > 4·2^ADRESSBREITE → FEHLER; else → RAMLADEN.
  - RAMLADEN (4): request the next payload byte, wait for `SDFertig`, merge the byte into the word buffer.
    - On the 4th byte of a word: pulse the write, increment `RAMAdresse`, clear the buffer.
    - After byte N-1 with a partial word: write it with the missing upper bytes set to 0.
    - When the last byte is written → RAMLADENBEENDEN.
  - RAMLADENBEENDEN (5): one-cycle settle; no outputs change → LAEUFT.
  - LAEUFT (6): `CPUReset`=0, `Fertig`=1; `RAMSchreibenAn` forced to 0. Terminal until `Reset`.
  - FEHLER (7): `Fehler`=1, `CPUReset`=1. Terminal until `Reset`.
- Request rule: `SDLesen` fires only when all three hold:
  - the state needs a byte,
  - the pause counter is 0,
  - `SDBusy`=0.
- After a request is issued, the pause counter loads `PAUSE` when `SDFertig` arrives and decrements to 0.
- `SDFertig` with no outstanding request is ignored.
- Counters: 32-bit byte counter, no wrap. `SDAdresse` = `STARTADRESSE` + 4 + k in payload states.

## Timing
- Reset values:
  - `SDLesen`=0, `SDAdresse`=`STARTADRESSE`.
  - `RAMSchreibenAn`=0, `RAMAdresse`=0, `RAMDatenRein`=0.
  - `CPUReset`=1, `Fertig`=0, `Fehler`=0, `Zustand`=0.
- `Reset` during any state, including mid-request, returns to RESET on the next edge. Any late `SDFertig` is then ignored. `Reset` wins over a simultaneous `SDFertig`.
- Write latency: `RAMSchreibenAn` is high exactly one cycle, on the cycle after the `SDFertig` that completes a word. `RAMAdresse` and `RAMDatenRein` are valid in that same cycle.
- Request spacing: at least `PAUSE`+1 cycles from `SDFertig` to the next `SDLesen`. With `PAUSE`=0, the next request can follow on the cycle after `SDFertig`.
- `CPUReset` falls and `Fertig` rises together, 2 cycles after the final write strobe (via RAMLADENBEENDEN).
- `SDBusy` high holds a pending request indefinitely; no timeout.

## Structure
- Shared package `lader_pkg` holds:
  - state encodings RESET..FEHLER (3-bit),
  - the header length constant (4).
  - The top level uses these encodings to decode `Zustand` onto the LEDs.
- Sub-module `wort_sammler`: byte-to-word assembler.
  - Inputs: byte strobe, byte, last-byte flag.
  - Outputs: 32-bit word and word-valid pulse.
  - Keeps the zero-padding rule in one place.
- RAM port multiplexing (loader vs. CPU, selected by `Fertig`) stays in the top level, not in this block.

## Test plan
- Header N=8, payload 11 22 33 44 55 66 77 88, `PAUSE`=2 → RAM[0]=0x44332211, RAM[1]=0x88776655. Exactly 2 write strobes; `Fertig`=1; `CPUReset`=0.
- N=5, payload AA BB CC DD EE → RAM[0]=0xDDCCBBAA, RAM[1]=0x000000EE (zero-padded).
- N=0 → FEHLER (`Zustand`=7), `Fehler`=1, `CPUReset` stays 1, no write strobe. Repeat with N=0x00040001 and `ADRESSBREITE`=16 → same result.
- Hold `SDBusy`=1 for 50 cycles after N is read → no `SDLesen` during the hold. Measure `SDFertig`→`SDLesen` gap ≥ `PAUSE`+1; spurious `SDFertig` without a request is ignored.
- Assert `Reset` for 1 cycle while in RAMLADEN after 6 of 8 bytes → all outputs return to reset values, then reload from the header. Final RAM contents match scenario 1.
- Reset asserted in the same cycle as `SDFertig` → byte discarded, `Zustand`=0 next cycle.

Source files
------------

// File: rtl/lader_pkg.sv
// Shared definitions for the boot loader: sequencer state encodings and image header size.
package lader_pkg;

    localparam int HEADER_LAENGE = 4;

    typedef enum logic [2:0] {
        RESET            = 3'd0,
        GROESSELADEN     = 3'd1,
        AUFGROESSEWARTEN = 3'd2,
        PRUEFEN          = 3'd3,
        RAMLADEN         = 3'd4,
        RAMLADENBEENDEN  = 3'd5,
        LAEUFT           = 3'd6,
        FEHLER           = 3'd7
    } zustand_t;

endpackage

// File: rtl/wort_sammler.sv
// Packs little-endian payload bytes into 32-bit RAM words; a short final word
// is emitted with its missing upper bytes as zero.
module wort_sammler (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        byteStrobe,
    input  logic [7:0]  datenByte,
    input  logic        letztesByte,
    output logic [31:0] wort,
    output logic        wortGueltig
);

    logic [31:0] puffer;
    logic [31:0] gemischt;
    logic [1:0]  index;

    // NOTE: default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        gemischt = puffer;
        gemischt[{index, 3'b000} +: 8] = datenByte;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            puffer      <= 32'd0;
            index       <= 2'd0;
            wort        <= 32'd0;
            wortGueltig <= 1'b0;
        end else begin
            wortGueltig <= 1'b0;
            if (byteStrobe) begin
                if (index == 2'd3 || letztesByte) begin
                    // Buffer restarts at zero, which is what pads a short last word.
                    wort        <= gemischt;
                    wortGueltig <= 1'b1;
                    puffer      <= 32'd0;
                    index       <= 2'd0;
                end else begin
                    puffer <= gemischt;
                    index  <= index + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/programm_lader.sv
// Boot sequencer: reads a length-prefixed image from the SD reader into RAM,
// then releases the CPU from reset (or parks in FEHLER on a bad header).
module programm_lader
    import lader_pkg::*;
#(
    parameter int          ADRESSBREITE = 16,
    parameter int          PAUSE        = 16,
    parameter logic [31:0] STARTADRESSE = 32'd0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    output logic                    SDLesen,
    output logic [31:0]             SDAdresse,
    input  logic [7:0]              SDDaten,
    input  logic                    SDFertig,
    input  logic                    SDBusy,
    output logic                    RAMSchreibenAn,
    output logic [ADRESSBREITE-1:0] RAMAdresse,
    output logic [31:0]             RAMDatenRein,
    output logic                    CPUReset,
    output logic                    Fertig,
    output logic                    Fehler,
    output logic [2:0]              Zustand
);

    localparam logic [63:0] KAPAZITAET = 64'd4 << ADRESSBREITE;

    zustand_t    zustand;
    logic        anfrageOffen;
    logic [31:0] pauseZaehler;
    logic [31:0] groesse;
    logic [2:0]  kopfZaehler;
    logic [31:0] byteZaehler;
    logic        wortGueltig;

    // A response only counts if this block has a request outstanding.
    wire darfAnfragen = (pauseZaehler == 32'd0) && !SDBusy;
    wire byteStrobe   = (zustand == RAMLADEN) && anfrageOffen && SDFertig;
    wire letztesByte  = (byteZaehler == groesse - 32'd1);

    wort_sammler sammler (
        .Clock       (Clock),
        .Reset       (Reset),
        .byteStrobe  (byteStrobe),
        .datenByte   (SDDaten),
        .letztesByte (letztesByte),
        .wort        (RAMDatenRein),
        .wortGueltig (wortGueltig)
    );

    assign RAMSchreibenAn = wortGueltig && (zustand != LAEUFT);
    assign Zustand        = zustand;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // decision below sees the values from before the clock edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand      <= RESET;
            SDLesen      <= 1'b0;
            SDAdresse    <= STARTADRESSE;
            RAMAdresse   <= '0;
            CPUReset     <= 1'b1;
            Fertig       <= 1'b0;
            Fehler       <= 1'b0;
            anfrageOffen <= 1'b0;
            pauseZaehler <= 32'd0;
            groesse      <= 32'd0;
            kopfZaehler  <= 3'd0;
            byteZaehler  <= 32'd0;
        end else begin
            SDLesen <= 1'b0;
            if (pauseZaehler != 32'd0) pauseZaehler <= pauseZaehler - 32'd1;
            if (RAMSchreibenAn) RAMAdresse <= RAMAdresse + ADRESSBREITE'(1);

            case (zustand)
                RESET: zustand <= GROESSELADEN;

                GROESSELADEN: if (darfAnfragen) begin
                    SDLesen      <= 1'b1;
                    anfrageOffen <= 1'b1;
                    SDAdresse    <= STARTADRESSE + 32'(kopfZaehler);
                    zustand      <= AUFGROESSEWARTEN;
                end

                AUFGROESSEWARTEN: if (anfrageOffen && SDFertig) begin
                    groesse      <= {SDDaten, groesse[31:8]};
                    anfrageOffen <= 1'b0;
                    pauseZaehler <= 32'(PAUSE);
                    kopfZaehler  <= kopfZaehler + 3'd1;
                    zustand      <= (kopfZaehler == 3'(HEADER_LAENGE - 1)) ? PRUEFEN : GROESSELADEN;
                end

                PRUEFEN: if (groesse == 32'd0 || {32'd0, groesse} > KAPAZITAET) begin
                    zustand <= FEHLER;
                    Fehler  <= 1'b1;
                end else begin
                    zustand <= RAMLADEN;
                end

                RAMLADEN: begin
                    if (!anfrageOffen && byteZaehler != groesse && darfAnfragen) begin
                        SDLesen      <= 1'b1;
                        anfrageOffen <= 1'b1;
                        SDAdresse    <= STARTADRESSE + 32'(HEADER_LAENGE) + byteZaehler;
                    end
                    if (byteStrobe) begin
                        anfrageOffen <= 1'b0;
                        pauseZaehler <= 32'(PAUSE);
                        byteZaehler  <= byteZaehler + 32'd1;
                    end
                    // Leave only once the strobe for the final word is on the port.
                    if (wortGueltig && byteZaehler == groesse) zustand <= RAMLADENBEENDEN;
                end

                RAMLADENBEENDEN: begin
                    zustand  <= LAEUFT;
                    CPUReset <= 1'b0;
                    Fertig   <= 1'b1;
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_programm_lader.sv
// Scoreboard bench for programm_lader: SD card responder model, RAM write monitor,
// directed images with hand-computed RAM words.
module tb_programm_lader;

    localparam int          ADRESSBREITE   = 16;
    localparam int          PAUSE          = 2;
    localparam logic [31:0] STARTADRESSE   = 32'h0000_0200;
    localparam int          ANTWORT_LATENZ = 3;

    typedef struct packed {
        logic [15:0] adr;
        logic [31:0] daten;
    } schreib_t;

    logic                    Clock = 1'b0;
    logic                    resetMain, resetModel, resetGesamt;
    logic                    sdFertigModel, sdFertigExtra;
    logic [7:0]              sdDatenModel, sdDatenExtra;
    logic                    SDBusy;
    logic                    SDLesen;
    logic [31:0]             SDAdresse;
    logic                    RAMSchreibenAn;
    logic [ADRESSBREITE-1:0] RAMAdresse;
    logic [31:0]             RAMDatenRein;
    logic                    CPUReset, Fertig, Fehler;
    logic [2:0]              Zustand;

    int       anzahlVergleiche = 0;
    int       anzahlFehler     = 0;
    int       zyklus           = 0;
    int       resetGeneration  = 0;
    int       nutzAntworten    = 0;
    int       schreibZaehler   = 0;
    int       letzterStrobe    = 0;
    int       letzteFertig     = -1;
    bit       resetMitAntwort  = 1'b0;
    logic [7:0]  sdBild [0:63];
    logic [31:0] ramModell [0:15];
    schreib_t erwartet [$];

    assign resetGesamt = resetMain | resetModel;

    always #20 Clock = ~Clock;
    always @(posedge Clock) zyklus <= zyklus + 1;

    programm_lader #(
        .ADRESSBREITE (ADRESSBREITE),
        .PAUSE        (PAUSE),
        .STARTADRESSE (STARTADRESSE)
    ) dut (
        .Clock          (Clock),
        .Reset          (resetGesamt),
        .SDLesen        (SDLesen),
        .SDAdresse      (SDAdresse),
        .SDDaten        (sdFertigExtra ? sdDatenExtra : sdDatenModel),
        .SDFertig       (sdFertigModel | sdFertigExtra),
        .SDBusy         (SDBusy),
        .RAMSchreibenAn (RAMSchreibenAn),
        .RAMAdresse     (RAMAdresse),
        .RAMDatenRein   (RAMDatenRein),
        .CPUReset       (CPUReset),
        .Fertig         (Fertig),
        .Fehler         (Fehler),
        .Zustand        (Zustand)
    );

    task automatic check(input string name, input logic [63:0] ist, input logic [63:0] soll);
        anzahlVergleiche++;
        if (ist !== soll) begin
            anzahlFehler++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, ist, soll, zyklus);
        end
    endtask

    function automatic logic [7:0] bildByte(input logic [31:0] adr);
        logic [31:0] versatz;
        versatz = adr - STARTADRESSE;
        return (versatz < 32'd64) ? sdBild[versatz[5:0]] : 8'hEE;
    endfunction

    task automatic setzeBild(input logic [31:0] n, input logic [63:0] nutz);
        for (int i = 0; i < 64; i++) sdBild[i] = 8'h00;
        for (int i = 0; i < 4; i++)  sdBild[i] = n[8*i +: 8];
        for (int i = 0; i < 8; i++)  sdBild[4+i] = nutz[8*i +: 8];
    endtask

    task automatic neuesSzenario();
        schreibZaehler = 0;
        for (int i = 0; i < 16; i++) ramModell[i] = 32'hDEAD_BEEF;
    endtask

    task automatic erwarteSchreiben(input logic [15:0] adr, input logic [31:0] daten);
        schreib_t s;
        s.adr   = adr;
        s.daten = daten;
        erwartet.push_back(s);
    endtask

    task automatic resetImpuls(input string name);
        @(negedge Clock);
        resetMain = 1'b1;
        resetGeneration++;
        @(negedge Clock);
        check({name, "_sdlesen"},   SDLesen,        1'b0);
        check({name, "_sdadresse"}, SDAdresse,      STARTADRESSE);
        check({name, "_schreiben"}, RAMSchreibenAn, 1'b0);
        check({name, "_ramadr"},    RAMAdresse,     16'd0);
        check({name, "_ramdaten"},  RAMDatenRein,   32'd0);
        check({name, "_cpureset"},  CPUReset,       1'b1);
        check({name, "_fertig"},    Fertig,         1'b0);
        check({name, "_fehler"},    Fehler,         1'b0);
        check({name, "_zustand"},   Zustand,        3'd0);
        resetMain = 1'b0;
    endtask

    task automatic warteAufZustand(input logic [2:0] ziel, input int budget, input string name);
        int n = 0;
        while (Zustand !== ziel && n < budget) begin
            @(negedge Clock);
            n++;
        end
        check(name, Zustand, ziel);
    endtask

    task automatic pruefeLauf(input string name, input int strobes);
        warteAufZustand(3'd6, 3000, {name, "_laeuft"});
        check({name, "_fertig_abstand"}, zyklus - letzterStrobe, 2);
        check({name, "_fertig"},   Fertig,   1'b1);
        check({name, "_cpureset"}, CPUReset, 1'b0);
        check({name, "_fehler"},   Fehler,   1'b0);
        repeat (3) @(negedge Clock);
        check({name, "_strobes"},  schreibZaehler,  strobes);
        check({name, "_rest"},     erwartet.size(), 0);
    endtask

    task automatic pruefeFehler(input string name);
        warteAufZustand(3'd7, 1000, {name, "_zustand"});
        check({name, "_fehler"},   Fehler,   1'b1);
        check({name, "_cpureset"}, CPUReset, 1'b1);
        check({name, "_fertig"},   Fertig,   1'b0);
        repeat (20) @(negedge Clock);
        check({name, "_bleibt"},   Zustand,        3'd7);
        check({name, "_strobes"},  schreibZaehler, 0);
    endtask

    // SD reader model: answers each request after a fixed latency; a reset
    // in between cancels the answer.
    initial begin : sdModell
        logic [31:0] adr;
        int          gen;
        bit          abgebrochen;
        bit          pruefeReset;
        sdFertigModel = 1'b0;
        sdDatenModel  = 8'h00;
        resetModel    = 1'b0;
        pruefeReset   = 1'b0;
        forever begin
            @(negedge Clock);
            sdFertigModel = 1'b0;
            resetModel    = 1'b0;
            if (pruefeReset) begin
                pruefeReset = 1'b0;
                check("reset_mit_fertig_zustand",  Zustand,  3'd0);
                check("reset_mit_fertig_sdlesen",  SDLesen,  1'b0);
                check("reset_mit_fertig_cpureset", CPUReset, 1'b1);
            end
            if (SDLesen) begin
                adr         = SDAdresse;
                gen         = resetGeneration;
                abgebrochen = 1'b0;
                for (int i = 0; i < ANTWORT_LATENZ; i++) begin
                    @(negedge Clock);
                    if (gen != resetGeneration) begin
                        abgebrochen = 1'b1;
                        break;
                    end
                end
                if (!abgebrochen) begin
                    sdDatenModel  = bildByte(adr);
                    sdFertigModel = 1'b1;
                    if (adr >= STARTADRESSE + 32'd4) nutzAntworten++;
                    if (resetMitAntwort) begin
                        resetMitAntwort = 1'b0;
                        resetModel      = 1'b1;
                        resetGeneration++;
                        pruefeReset     = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: RAM writes against the scoreboard, request spacing after each response.
    initial begin : monitor
        schreib_t soll;
        forever begin
            @(negedge Clock);
            #1;
            if (SDLesen && letzteFertig >= 0) begin
                check("sd_abstand_ok", (zyklus - letzteFertig) >= PAUSE + 1, 1'b1);
                letzteFertig = -1;
            end
            if (resetGesamt) letzteFertig = -1;
            else if (sdFertigModel) letzteFertig = zyklus + 1;
            if (RAMSchreibenAn) begin
                schreibZaehler++;
                letzterStrobe = zyklus;
                ramModell[RAMAdresse[3:0]] = RAMDatenRein;
                if (erwartet.size() == 0) begin
                    anzahlVergleiche++;
                    anzahlFehler++;
                    $display("FAIL unerwartetes_schreiben: got write adr=0x%0h data=0x%0h, expected none",
                             RAMAdresse, RAMDatenRein);
                end else begin
                    soll = erwartet.pop_front();
                    check("schreib_adr",   RAMAdresse,   soll.adr);
                    check("schreib_daten", RAMDatenRein, soll.daten);
                end
            end
        end
    end

    initial begin : ablauf
        int basis, anfragen, n;
        resetMain    = 1'b1;
        SDBusy       = 1'b0;
        sdFertigExtra = 1'b0;
        sdDatenExtra = 8'h00;

        // N=8, two full words
        setzeBild(32'd8, 64'h8877_6655_4433_2211);
        neuesSzenario();
        erwarteSchreiben(16'd0, 32'h4433_2211);
        erwarteSchreiben(16'd1, 32'h8877_6655);
        resetImpuls("s1_reset");
        pruefeLauf("s1", 2);
        check("s1_ram0", ramModell[0], 32'h4433_2211);
        check("s1_ram1", ramModell[1], 32'h8877_6655);

        // N=5, zero-padded last word
        setzeBild(32'd5, 64'h0000_00EE_DDCC_BBAA);
        neuesSzenario();
        erwarteSchreiben(16'd0, 32'hDDCC_BBAA);
        erwarteSchreiben(16'd1, 32'h0000_00EE);
        resetImpuls("s2_reset");
        pruefeLauf("s2", 2);
        check("s2_ram0", ramModell[0], 32'hDDCC_BBAA);
        check("s2_ram1", ramModell[1], 32'h0000_00EE);

        // invalid sizes: zero, and one byte past capacity
        setzeBild(32'd0, 64'h0);
        neuesSzenario();
        resetImpuls("s3a_reset");
        pruefeFehler("s3a");
        setzeBild(32'h0004_0001, 64'h0);
        neuesSzenario();
        resetImpuls("s3b_reset");
        pruefeFehler("s3b");

        // SDBusy hold plus a stray SDFertig while nothing is outstanding
        setzeBild(32'd8, 64'h8877_6655_4433_2211);
        neuesSzenario();
        erwarteSchreiben(16'd0, 32'h4433_2211);
        erwarteSchreiben(16'd1, 32'h8877_6655);
        resetImpuls("s4_reset");
        warteAufZustand(3'd3, 500, "s4_pruefen");
        SDBusy   = 1'b1;
        anfragen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            if (SDLesen) anfragen++;
            if (i == 10) begin
                sdFertigExtra = 1'b1;
                sdDatenExtra  = 8'h5A;
            end
            if (i == 11) sdFertigExtra = 1'b0;
        end
        check("s4_busy_keine_anfrage", anfragen, 0);
        SDBusy = 1'b0;
        pruefeLauf("s4", 2);
        check("s4_ram0", ramModell[0], 32'h4433_2211);
        check("s4_ram1", ramModell[1], 32'h8877_6655);

        // reset after 6 of 8 payload bytes, then a full reload
        neuesSzenario();
        erwarteSchreiben(16'd0, 32'h4433_2211);
        erwarteSchreiben(16'd0, 32'h4433_2211);
        erwarteSchreiben(16'd1, 32'h8877_6655);
        resetImpuls("s5_reset");
        basis = nutzAntworten;
        n     = 0;
        while (nutzAntworten - basis < 6 && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        check("s5_sechs_bytes", (nutzAntworten - basis) >= 6, 1'b1);
        resetImpuls("s5_mitten");
        pruefeLauf("s5", 3);
        check("s5_ram0", ramModell[0], 32'h4433_2211);
        check("s5_ram1", ramModell[1], 32'h8877_6655);

        // Reset coincides with the first header response
        neuesSzenario();
        erwarteSchreiben(16'd0, 32'h4433_2211);
        erwarteSchreiben(16'd1, 32'h8877_6655);
        resetMitAntwort = 1'b1;
        resetImpuls("s6_reset");
        pruefeLauf("s6", 2);
        check("s6_reset_ausgeloest", resetMitAntwort, 1'b0);
        check("s6_ram0", ramModell[0], 32'h4433_2211);
        check("s6_ram1", ramModell[1], 32'h8877_6655);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", anzahlVergleiche, anzahlFehler);
        $finish;
    end

    initial begin : wachhund
        #(40 * 60000);
        $display("FAIL watchdog: got no end of run, expected completion within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
